muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own control FSM, sitting in EX beside the ALU.
- Decoder raises Start for OP (R-type) with Funct7 = 0000001; Funct3 selects the operation.
- The block latches operands, runs a radix-2 shift-add or restoring-divide loop over XLEN cycles, then returns the result with a one-cycle Done pulse.
- Stall freezes PC, IF/ID and ID/EX while the operation is in flight.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  M-extension instruction present in EX; held high by the stalled pipeline.
- Funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  rs1 operand (multiplicand/dividend).
- SrcB  input  XLEN  rs2 operand (multiplier/divisor).
- Flush  input  1  synchronous abort (branch/trap squash of EX).
- Result  output  XLEN  registered result; valid while Done=1, then held until the next accept.
- Done  output  1  one-cycle result-valid pulse.
- Busy  output  1  high in CALC, FIXUP and DONE.
- Stall  output  1  combinational: Start & ~Done.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; Result=0, Done=0, Busy=0; counter, operand and accumulator registers = 0. Stall follows Start.
- States:
  - IDLE: if Start & ~Flush, latch Funct3, |SrcA|, |SrcB|, sign flags and special-case flags; counter=0.
    - Next state is DONE if the special case applies, otherwise CALC.
  - CALC: one iteration per cycle; counter increments; after iteration XLEN (counter = XLEN-1 at the edge) go to FIXUP.
  - FIXUP: apply sign correction, select high/low half or quotient/remainder, register Result; go to DONE.
  - DONE: Done=1 for exactly one cycle; go to IDLE. Start seen in DONE is ignored because it is the same instruction.
- Latency: Start first high in cycle 0 (IDLE). CALC occupies cycles 1..XLEN, FIXUP is cycle XLEN+1, Done is high in cycle XLEN+2 (34 for XLEN=32).
  - Stall is high in cycles 0..XLEN+1 and low in the Done cycle.
  - Special cases: Done in cycle 1.
  - Back-to-back ops: the next Start is accepted in the IDLE cycle after DONE.
- Operands and Funct3 are captured at accept; changes on SrcA, SrcB or Funct3 during CALC, FIXUP or DONE are ignored.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Arithmetic: operate on magnitudes.
  - Multiply: 2*XLEN product; negate in FIXUP if the product sign (sA^sB) is set. MUL returns the low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits.
  - Divide (restoring): quotient is negated if sA^sB; remainder takes the dividend sign.
- Special cases (no CALC):
  - Divisor 0: quotient = all ones, remainder = SrcA (signed and unsigned).
  - Signed overflow (SrcA = most-negative, SrcB = -1, DIV/REM only): quotient = SrcA, remainder = 0.
- Flush: synchronous, highest priority after reset. Any state goes to IDLE with Done=0, Busy=0; Result keeps its previous value. Flush with Start in IDLE means no accept.
- Reset mid-operation: immediate IDLE, outputs 0; no Done is ever produced for the aborted op.
- Start=0 in IDLE: remain IDLE; outputs unchanged.

Test Plan:
1. MUL SrcA=7, SrcB=0xFFFFFFFD (-3) -> Result=0xFFFFFFEB. Done exactly in cycle 34; Stall high cycles 0..33 and low in cycle 34; Busy high cycles 1..34.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF. Run back-to-back: each accepted one cycle after the previous Done.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Toggle SrcA mid-CALC -> results unaffected.
4. DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each has Done in cycle 1.
5. Start MUL, assert Flush in cycle 10 -> Busy=0 in cycle 11, no Done pulse, Result unchanged. A new DIVU 9/3 started in cycle 12 -> Result=3, Done in cycle 12+34.
6. rst_n low in cycle 20 of a DIV -> Busy, Done and Result are 0 before the next clock edge. After release with Start=0, the block stays IDLE; a subsequent MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle over XLEN cycles, with sign fix-up and divide special cases.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic [XLEN-1:0] Result,
  output logic            Done,
  output logic            Busy,
  output logic            Stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   mul_sum;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign signed_a = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
  assign signed_b = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign neg_a    = signed_a & SrcA[XLEN-1];
  assign neg_b    = signed_b & SrcB[XLEN-1];
  assign mag_a    = neg_a ? -SrcA : SrcA;
  assign mag_b    = neg_b ? -SrcB : SrcB;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero    = Funct3[2] && (SrcB == '0);
  assign div_ovf     = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcB);
  assign special_res = div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);

  // hi_q is the product high half / partial remainder; lo_q holds multiplier / dividend bits.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_ge   = {hi_q, lo_q[XLEN-1]} >= {1'b0, opb_q};
  assign div_diff = XLEN'({hi_q, lo_q[XLEN-1]} - {1'b0, opb_q});

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_d   = Funct3;
            neg_d  = neg_a ^ neg_b;
            rneg_d = neg_a;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = Funct3[2] ? mag_a : mag_b;
            opb_d  = Funct3[2] ? mag_b : mag_a;
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            hi_d = div_ge ? div_diff : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          if (op_q[2])
            result_d = op_q[1] ? rem_fix : quo_fix;
          else if (op_q == 3'b000)
            result_d = prod_fix[XLEN-1:0];
          else
            result_d = prod_fix[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;
  assign Done   = (state_q == S_DONE);
  assign Busy   = (state_q != S_IDLE);
  assign Stall  = Start & ~Done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected results and
// Done cycles; a monitor pops and compares whenever Done is seen.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] Result;
  logic        Done, Busy, Stall;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Result(Result), .Done(Done), .Busy(Busy), .Stall(Stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, " result"}, Result, e.res);
        check({e.name, " done_cycle"}, cyc, e.at);
        $display("txn %s result=%h done_cycle=%0d", e.name, Result, cyc);
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit chk, input bit toggle);
    int  c;
    bit  got;
    @(negedge clk);
    Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    c = cyc;
    sb.push_back('{exp, c + lat, name});
    last_res = exp;
    if (chk) begin
      #1;
      check({name, " stall_c0"}, 32'(Stall), 32'd1);
      check({name, " busy_c0"}, 32'(Busy), 32'd0);
    end
    got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (toggle && k == 5) begin
        SrcA = ~SrcA; SrcB = SrcB + 32'd1; Funct3 = Funct3 ^ 3'b001;
      end
      if (chk && k <= lat) begin
        check($sformatf("%s stall_c%0d", name, k), 32'(Stall), (k < lat) ? 32'd1 : 32'd0);
        check($sformatf("%s busy_c%0d", name, k), 32'(Busy), 32'd1);
      end
      if (Done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no Done expected Done within 100 cycles", name);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    int c;
    // Reset state; Stall follows Start even in reset.
    repeat (2) @(negedge clk);
    check("rst result", Result, 32'd0);
    check("rst done", 32'(Done), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    Start = 1'b1; #1;
    check("rst stall_follows_start", 32'(Stall), 32'd1);
    Start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", 32'(Busy), 32'd0);

    issue("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1, 1'b0);
    idle();

    issue("MULH", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0, 1'b0);
    issue("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0, 1'b0);
    issue("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, 1'b0, 1'b0);
    idle();

    issue("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b1, 1'b0);
    idle();
    issue("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b1, 1'b0);
    idle();
    issue("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1, 1'b0);
    idle();
    issue("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b1, 1'b0);
    idle();

    issue("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0, 1'b1);
    issue("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0, 1'b1);
    issue("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0, 1'b0);
    issue("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0, 1'b1);
    idle();

    // Flush mid-CALC: no Done, Busy drops, Result holds.
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd6;
    c = cyc;
    while (cyc < c + 10) @(negedge clk);
    check("flush busy_c10", 32'(Busy), 32'd1);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0;
    check("flush busy_c11", 32'(Busy), 32'd0);
    check("flush done_c11", 32'(Done), 32'd0);
    check("flush result_hold", Result, last_res);
    issue("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34, 1'b0, 1'b0);
    idle();

    // Asynchronous reset mid-DIV.
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'b100; SrcA = 32'hFFFFFF9C; SrcB = 32'd7;
    c = cyc;
    while (cyc < c + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(Busy), 32'd0);
    check("arst done", 32'(Done), 32'd0);
    check("arst result", Result, 32'd0);
    Start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst idle busy_%0d", k), 32'(Busy), 32'd0);
    end
    issue("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b0, 1'b0);
    idle();

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
